mmm_out_framer: RTL and testbench

Downstream stage of the matrix-multiply engine. Consumes its OUTW-bit signed result stream, one result per beat in row-major order, M×N results per matrix. Requantizes each result to QW bits (rounding arithmetic right shift, then saturation). Emits a framed AXI-Stream with row-end and matrix-end markers. A 2-entry skid buffer keeps throughput at one beat/cycle and keeps the upstream ready registered.

---
 rtl/mmm_pkg.sv | 47 ++++
 rtl/mmm_out_framer_if.sv | 13 +
 rtl/axis_skid.sv | 93 +++++++++
 rtl/mmm_out_framer.sv | 102 ++++++++++
 tb/tb_mmm_out_framer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/mmm_pkg.sv
// Shared types and the requantize/saturate helper for the matrix-multiply
// output framer.
package mmm_pkg;

  localparam int QW_DEF = 16;

  typedef enum logic [1:0] {
    SKID_EMPTY,
    SKID_ONE,
    SKID_FULL
  } skid_state_t;

  typedef struct packed {
    logic signed [QW_DEF-1:0] data;
    logic                     tuser;
    logic                     tlast;
  } beat_t;

  // Wide enough for any OUTW up to 64 plus the rounding carry bit.
  typedef struct packed {
    logic signed [64:0] data;
    logic               clip;
  } rq_t;

  // Round-half-up arithmetic right shift, then clip to a signed qw-bit range.
  function automatic rq_t requant_sat(input logic signed [64:0] x,
                                      input int sh,
                                      input int qw);
    logic signed [64:0] rnd;
    logic signed [64:0] sum;
    logic signed [64:0] r;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    rq_t                res;
    rnd = (sh > 0) ? (65'sd1 <<< (sh - 1)) : 65'sd0;
    sum = x + rnd;
    r   = sum >>> sh;
    hi  = (65'sd1 <<< (qw - 1)) - 65'sd1;
    lo  = -(65'sd1 <<< (qw - 1));
    res.clip = (r > hi) || (r < lo);
    if (r > hi)      res.data = hi;
    else if (r < lo) res.data = lo;
    else             res.data = r;
    return res;
  endfunction

endpackage

// File: rtl/mmm_out_framer_if.sv
// AXI-Stream style bundle used for both the result input and framed output.
interface mmm_out_framer_if #(parameter int W = 16);
  logic [W-1:0] TDATA;
  logic         TVALID;
  logic         TREADY;
  logic         TUSER;
  logic         TLAST;

  modport master (output TDATA, output TVALID, output TUSER, output TLAST,
                  input TREADY);
  modport slave  (input TDATA, input TVALID, input TUSER, input TLAST,
                  output TREADY);
endinterface

// File: rtl/axis_skid.sv
// Two-entry skid buffer with registered upstream ready.
//
// state      | meaning
// SKID_EMPTY | nothing held, output idle
// SKID_ONE   | main register holds the beat on the output
// SKID_FULL  | main on the output, skid holds the next beat, upstream stalled
module axis_skid
  import mmm_pkg::*;
#(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  skid_state_t  state_q;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         in_ready_q;
  logic         out_valid_q;

  logic acc;
  logic xfer;

  assign acc  = in_valid_i && in_ready_q;
  assign xfer = out_valid_q && out_ready_i;

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = main_q;

  // Buffer FSM; ready is registered as "next state is not FULL".
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SKID_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          in_ready_q <= 1'b1;
          if (acc) begin
            main_q      <= in_data_i;
            out_valid_q <= 1'b1;
            state_q     <= SKID_ONE;
          end
        end
        SKID_ONE: begin
          case ({acc, xfer})
            2'b10: begin
              skid_q     <= in_data_i;
              state_q    <= SKID_FULL;
              in_ready_q <= 1'b0;
            end
            2'b01: begin
              out_valid_q <= 1'b0;
              state_q     <= SKID_EMPTY;
              in_ready_q  <= 1'b1;
            end
            2'b11: begin
              main_q     <= in_data_i;
              in_ready_q <= 1'b1;
            end
            default: in_ready_q <= 1'b1;
          endcase
        end
        SKID_FULL: begin
          if (xfer) begin
            main_q     <= skid_q;
            state_q    <= SKID_ONE;
            in_ready_q <= 1'b1;
          end else begin
            in_ready_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= SKID_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mmm_out_framer.sv
// Requantizes engine results and frames them with row-end (TUSER) and
// matrix-end (TLAST) markers, buffered through a two-entry skid.
module mmm_out_framer
  import mmm_pkg::*;
#(
  parameter  int OUTW = 32,
  parameter  int QW   = 16,
  parameter  int M    = 7,
  parameter  int N    = 9,
  localparam int SHW  = $clog2(OUTW)
) (
  input  logic             clk,
  input  logic             reset,
  mmm_out_framer_if.slave  IN,
  input  logic [SHW-1:0]   shift,
  mmm_out_framer_if.master OUTPUT,
  output logic [15:0]      sat_count
);

  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(M - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(N - 1);

  logic [RW-1:0]  row_q, row_d;
  logic [CW-1:0]  col_q, col_d;
  logic [SHW-1:0] shift_q, shift_d;
  logic [15:0]    sat_q, sat_d;

  logic               skid_ready;
  logic               acc;
  logic               at_origin;
  logic [SHW-1:0]     sh_eff;
  logic signed [64:0] x_ext;
  rq_t                rq;
  logic [QW-1:0]      q_data;
  logic               tuser;
  logic               tlast;
  logic [QW+1:0]      skid_out;

  assign acc       = IN.TVALID && skid_ready;
  assign at_origin = (row_q == '0) && (col_q == '0);
  // The first beat of a matrix already uses the freshly sampled shift.
  assign sh_eff    = at_origin ? shift : shift_q;
  assign x_ext     = {{(65 - OUTW){IN.TDATA[OUTW-1]}}, IN.TDATA};
  assign rq        = requant_sat(x_ext, int'(sh_eff), QW);
  assign q_data    = QW'(rq.data);
  assign tuser     = (col_q == COL_LAST);
  assign tlast     = tuser && (row_q == ROW_LAST);

  assign IN.TREADY = skid_ready;
  assign sat_count = sat_q;

  // Position counters, per-matrix shift latch and saturating clip counter.
  always_comb begin
    row_d   = row_q;
    col_d   = col_q;
    shift_d = shift_q;
    sat_d   = sat_q;
    if (acc) begin
      if (at_origin) shift_d = shift;
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      if (rq.clip && (sat_q != 16'hFFFF)) sat_d = sat_q + 16'd1;
    end
  end

  // Register the framing state.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_q   <= '0;
      col_q   <= '0;
      shift_q <= '0;
      sat_q   <= '0;
    end else begin
      row_q   <= row_d;
      col_q   <= col_d;
      shift_q <= shift_d;
      sat_q   <= sat_d;
    end
  end

  axis_skid #(.W(QW + 2)) u_skid (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (IN.TVALID),
    .in_ready_o  (skid_ready),
    .in_data_i   ({q_data, tuser, tlast}),
    .out_valid_o (OUTPUT.TVALID),
    .out_ready_i (OUTPUT.TREADY),
    .out_data_o  (skid_out)
  );

  assign OUTPUT.TDATA = skid_out[QW+1:2];
  assign OUTPUT.TUSER = skid_out[1];
  assign OUTPUT.TLAST = skid_out[0];

endmodule

// File: tb/tb_mmm_out_framer.sv
// Scoreboard bench for mmm_out_framer: stimulus pushes expected beats,
// a negedge monitor pops and compares on every output transfer.
module tb_mmm_out_framer;
  import mmm_pkg::*;

  localparam int OUTW = 32;
  localparam int QW   = 16;
  localparam int M    = 7;
  localparam int N    = 9;
  localparam int SHW  = $clog2(OUTW);

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [SHW-1:0] shift = '0;
  logic [15:0]    sat_count;

  mmm_out_framer_if #(.W(OUTW)) in_if ();
  mmm_out_framer_if #(.W(QW))   out_if ();

  mmm_out_framer #(.OUTW(OUTW), .QW(QW), .M(M), .N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .IN        (in_if),
    .shift     (shift),
    .OUTPUT    (out_if),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    passes = 0;
  beat_t exp_q[$];
  beat_t e;
  beat_t held;
  logic  stalled_prev = 1'b0;
  int    pos = 0;
  int    n_acc = 0;
  int    n_xfer = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: counts handshakes for the upcoming edge, checks stall stability
  // and compares every transferred beat against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      stalled_prev = 1'b0;
    end else begin
      if (in_if.TVALID && in_if.TREADY) n_acc++;
      if (stalled_prev) begin
        chk("hold_valid", longint'(out_if.TVALID), 1);
        chk("hold_data", longint'($signed(out_if.TDATA)), longint'($signed(held.data)));
        chk("hold_tuser", longint'(out_if.TUSER), longint'(held.tuser));
        chk("hold_tlast", longint'(out_if.TLAST), longint'(held.tlast));
      end
      if (out_if.TVALID && out_if.TREADY) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_beat: got data %0d with empty scoreboard",
                   $signed(out_if.TDATA));
        end else begin
          e = exp_q.pop_front();
          chk("data", longint'($signed(out_if.TDATA)), longint'($signed(e.data)));
          chk("tuser", longint'(out_if.TUSER), longint'(e.tuser));
          chk("tlast", longint'(out_if.TLAST), longint'(e.tlast));
        end
      end
      stalled_prev = out_if.TVALID && !out_if.TREADY;
      held.data  = out_if.TDATA;
      held.tuser = out_if.TUSER;
      held.tlast = out_if.TLAST;
    end
  end

  // Issue one beat; expected framing comes from the bench's own position count.
  task automatic send(input longint val, input int expv);
    beat_t b;
    logic  ok;
    b.data  = QW_DEF'(expv);
    b.tuser = ((pos % N) == N - 1);
    b.tlast = (pos == M * N - 1);
    pos = (pos + 1) % (M * N);
    exp_q.push_back(b);
    in_if.TDATA  = val[OUTW-1:0];
    in_if.TVALID = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = in_if.TREADY;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      $display("FAIL send_timeout: got no accept for value %0d expected accept", val);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && exp_q.size() > 0; k++) @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_if.TVALID = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_in_tready", longint'(in_if.TREADY), 0);
    chk("rst_tvalid", longint'(out_if.TVALID), 0);
    chk("rst_tdata", longint'(out_if.TDATA), 0);
    chk("rst_tuser", longint'(out_if.TUSER), 0);
    chk("rst_tlast", longint'(out_if.TLAST), 0);
    chk("rst_sat_count", longint'(sat_count), 0);
    exp_q.delete();
    pos = 0;
    n_acc = 0;
    n_xfer = 0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("tready_rise", longint'(in_if.TREADY), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    in_if.TDATA  = '0;
    in_if.TVALID = 1'b0;
    in_if.TUSER  = 1'b0;
    in_if.TLAST  = 1'b0;
    out_if.TREADY = 1'b1;

    // Rounding, shift=4
    do_reset();
    shift = 5'd4;
    send(24, 2);
    chk("latency_valid", longint'(out_if.TVALID), 1);
    chk("latency_data", longint'($signed(out_if.TDATA)), 2);
    send(-24, -1);
    send(7, 0);
    send(8, 1);
    in_if.TVALID = 1'b0;
    drain();

    // Saturation, shift=0
    do_reset();
    shift = 5'd0;
    send(40000, 32767);
    send(-40000, -32768);
    send(32767, 32767);
    in_if.TVALID = 1'b0;
    drain();
    chk("sat_count", longint'(sat_count), 2);

    // Framing: two back-to-back matrices, value = index
    do_reset();
    shift = 5'd0;
    for (int i = 0; i < 2 * M * N; i++) send(i % (M * N), i % (M * N));
    in_if.TVALID = 1'b0;
    drain();

    // Backpressure: downstream stalls for 5 cycles mid-stream
    do_reset();
    fork
      begin
        for (int i = 0; i < 20; i++) send(1000 + i, 1000 + i);
        in_if.TVALID = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_if.TREADY = 1'b0;
        @(posedge clk);
        #2;
        chk("bp_buffered_first", n_acc - n_xfer, 2);
        chk("bp_in_tready_first", longint'(in_if.TREADY), 0);
        repeat (4) @(posedge clk);
        #2;
        chk("bp_buffered_last", n_acc - n_xfer, 2);
        chk("bp_in_tready_last", longint'(in_if.TREADY), 0);
        out_if.TREADY = 1'b1;
      end
    join
    drain();

    // Shift latch: changes mid-matrix wait for the next matrix
    do_reset();
    shift = 5'd2;
    for (int i = 0; i < 10; i++) send(100, 25);
    shift = 5'd6;
    for (int i = 10; i < M * N; i++) send(100, 25);
    for (int i = 0; i < N; i++) send(100, 2);
    in_if.TVALID = 1'b0;
    drain();

    // Reset mid-matrix with two beats buffered
    do_reset();
    shift = 5'd0;
    send(50000, 32767);
    for (int i = 1; i < 28; i++) send(i, i);
    in_if.TVALID = 1'b0;
    drain();
    out_if.TREADY = 1'b0;
    send(28, 28);
    send(29, 29);
    in_if.TVALID = 1'b0;
    chk("pre_reset_buffered", n_acc - n_xfer, 2);
    chk("pre_reset_sat", longint'(sat_count), 1);
    do_reset();
    out_if.TREADY = 1'b1;
    for (int i = 0; i < M * N; i++) send(i, i);
    in_if.TVALID = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
